// File: rtl/move_commit_if.sv
// Move packet handshake between the board/cursor controller (master) and
// the move commit block (slave), plus the per-move result it reports back.
interface move_commit_if;
  logic        move_valid;
  logic [11:0] move_packet;
  logic        move_ready;
  logic        move_done;
  logic        move_ok;
  logic [1:0]  err_code;
  logic [3:0]  captured_piece;

  modport master (
    output move_valid, move_packet,
    input  move_ready, move_done, move_ok, err_code, captured_piece
  );

  modport slave (
    input  move_valid, move_packet,
    output move_ready, move_done, move_ok, err_code, captured_piece
  );
endinterface

// File: rtl/move_commit.sv
// Authoritative board owner: accepts move packets, checks piece ownership,
// applies captures/promotion/king capture and advances the turn.
module move_commit #(
  parameter bit FIRST_PLAYER = 1'b1,
  parameter int CNT_W        = 10,
  parameter bit PROMOTE_EN   = 1'b1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     new_game,
  move_commit_if.slave             mv,
  output logic [7:0][7:0][3:0]     stable_board,
  output logic                     curr_player,
  output logic [CNT_W-1:0]         move_count,
  output logic                     game_over,
  output logic                     winner
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, DONE} state_t;

  localparam logic [3:0] EMPTY    = 4'd15;
  localparam logic [3:0] P1_PAWN  = 4'd0;
  localparam logic [3:0] P1_QUEEN = 4'd4;
  localparam logic [3:0] P1_KING  = 4'd5;
  localparam logic [3:0] P0_PAWN  = 4'd6;
  localparam logic [3:0] P0_QUEEN = 4'd10;
  localparam logic [3:0] P0_KING  = 4'd11;

  state_t state, state_nxt;

  logic [11:0] pkt;
  logic [1:0]  pend_err;
  logic [1:0]  check_err;
  logic [2:0]  src_x, src_y, dst_x, dst_y;
  logic [3:0]  src_piece, dst_piece, placed_piece;
  logic        ready_now;
  logic        latch_pkt, apply_move, finish;

  function automatic logic [3:0] back_rank(input logic [2:0] x);
    logic [3:0] p;
    case (x)
      3'd0, 3'd7: p = 4'd3;
      3'd1, 3'd6: p = 4'd1;
      3'd2, 3'd5: p = 4'd2;
      3'd3:       p = 4'd4;
      default:    p = 4'd5;
    endcase
    return p;
  endfunction

  function automatic logic [7:0][7:0][3:0] start_position();
    logic [7:0][7:0][3:0] b;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        b[3'(i)][3'(j)] = EMPTY;
      end
      b[3'(i)][0] = back_rank(3'(i));
      b[3'(i)][1] = P1_PAWN;
      b[3'(i)][6] = P0_PAWN;
      b[3'(i)][7] = back_rank(3'(i)) + 4'd6;
    end
    return b;
  endfunction

  // Player 1 owns codes 0..5, player 0 owns 6..11; empty belongs to nobody.
  function automatic logic owned(input logic [3:0] piece, input logic player);
    return player ? (piece <= 4'd5) : ((piece >= 4'd6) && (piece <= 4'd11));
  endfunction

  assign src_x     = pkt[11:9];
  assign src_y     = pkt[8:6];
  assign dst_x     = pkt[5:3];
  assign dst_y     = pkt[2:0];
  assign src_piece = stable_board[src_x][src_y];
  assign dst_piece = stable_board[dst_x][dst_y];

  always_comb begin
    check_err = 2'd0;
    if (src_piece == EMPTY)
      check_err = 2'd1;
    else if (!owned(src_piece, curr_player))
      check_err = 2'd2;
    else if (((src_x == dst_x) && (src_y == dst_y)) || owned(dst_piece, curr_player))
      check_err = 2'd3;
  end

  always_comb begin
    placed_piece = src_piece;
    if (PROMOTE_EN) begin
      if ((src_piece == P1_PAWN) && (dst_y == 3'd7))
        placed_piece = P1_QUEEN;
      else if ((src_piece == P0_PAWN) && (dst_y == 3'd0))
        placed_piece = P0_QUEEN;
    end
  end

  // Ready stays low during the move_done cycle so a result is never overlapped.
  assign ready_now     = (state == IDLE) && !game_over && !mv.move_done;
  assign mv.move_ready = ready_now;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_pkt  = 1'b0;
    apply_move = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (mv.move_valid && ready_now) begin
          latch_pkt = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = (check_err != 2'd0) ? DONE : APPLY;
      APPLY: begin
        apply_move = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new game aborts whatever is in flight, including a pending result.
    if (new_game) begin
      latch_pkt  = 1'b0;
      apply_move = 1'b0;
      finish     = 1'b0;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      stable_board      <= start_position();
      curr_player       <= FIRST_PLAYER;
      move_count        <= '0;
      game_over         <= 1'b0;
      winner            <= 1'b0;
      pkt               <= '0;
      pend_err          <= 2'd0;
      mv.move_done      <= 1'b0;
      mv.move_ok        <= 1'b0;
      mv.err_code       <= 2'd0;
      mv.captured_piece <= EMPTY;
    end else begin
      mv.move_done <= 1'b0;
      if (new_game) begin
        stable_board      <= start_position();
        curr_player       <= FIRST_PLAYER;
        move_count        <= '0;
        game_over         <= 1'b0;
        mv.captured_piece <= EMPTY;
      end else begin
        if (latch_pkt)
          pkt <= mv.move_packet;
        if (state == CHECK)
          pend_err <= check_err;
        if (apply_move) begin
          stable_board[dst_x][dst_y] <= placed_piece;
          stable_board[src_x][src_y] <= EMPTY;
          mv.captured_piece          <= dst_piece;
          curr_player                <= ~curr_player;
          if (move_count != '1)
            move_count <= move_count + 1'b1;
          if ((dst_piece == P1_KING) || (dst_piece == P0_KING)) begin
            game_over <= 1'b1;
            winner    <= curr_player;
          end
        end
        if (finish) begin
          mv.move_done <= 1'b1;
          mv.move_ok   <= (pend_err == 2'd0);
          mv.err_code  <= pend_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_move_commit.sv
// Directed bench for move_commit: a table of move packets with hand-computed
// results, plus sequences for promotion, king capture, new_game and reset.
module tb_move_commit;

  logic CLOCK_50 = 1'b0;
  logic reset_n;
  logic new_game;

  always #10 CLOCK_50 = ~CLOCK_50;

  move_commit_if bus();
  move_commit_if bus_np();

  logic [7:0][7:0][3:0] board, board_np;
  logic                 player, player_np;
  logic [9:0]           count, count_np;
  logic                 go, go_np;
  logic                 win, win_np;

  move_commit #(.FIRST_PLAYER(1'b1), .CNT_W(10), .PROMOTE_EN(1'b1)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .mv           (bus),
    .stable_board (board),
    .curr_player  (player),
    .move_count   (count),
    .game_over    (go),
    .winner       (win)
  );

  move_commit #(.FIRST_PLAYER(1'b1), .CNT_W(10), .PROMOTE_EN(1'b0)) dut_np (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .mv           (bus_np),
    .stable_board (board_np),
    .curr_player  (player_np),
    .move_count   (count_np),
    .game_over    (go_np),
    .winner       (win_np)
  );

  typedef struct {
    logic [11:0] pkt;
    int          lat;
    int          err;
    int          ok;
    int          cap;
    int          player;
    int          cnt;
    logic [2:0]  x1, y1;
    int          v1;
    logic [2:0]  x2, y2;
    int          v2;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  function automatic int start_sq(input logic [2:0] x, input logic [2:0] y);
    int back[8] = '{3, 1, 2, 4, 5, 2, 1, 3};
    if (y == 3'd0) return back[x];
    if (y == 3'd7) return back[x] + 6;
    if (y == 3'd1) return 0;
    if (y == 3'd6) return 6;
    return 15;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkStartBoard(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        if (int'(board[3'(i)][3'(j)]) != start_sq(3'(i), 3'(j)))    errs++;
        if (int'(board_np[3'(i)][3'(j)]) != start_sq(3'(i), 3'(j))) errs++;
      end
    checkOutput(name, errs, 0);
  endtask

  task automatic drive(input logic valid, input logic [11:0] pkt);
    bus.move_valid     = valid;
    bus.move_packet    = pkt;
    bus_np.move_valid  = valid;
    bus_np.move_packet = pkt;
  endtask

  task automatic doReset();
    drive(1'b0, 12'h000);
    new_game = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic pulseNewGame();
    @(negedge CLOCK_50);
    new_game = 1'b1;
    @(posedge CLOCK_50);
    #1;
    new_game = 1'b0;
  endtask

  // Waits (bounded) for ready, offers one packet, then counts edges after
  // the accepting edge until move_done is seen; lat=10 means it never came.
  task automatic applyStimulus(input logic [11:0] pkt, output int rdy_after, output int lat);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (!bus.move_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    drive(1'b1, pkt);
    @(posedge CLOCK_50);
    #1;
    rdy_after = int'(bus.move_ready);
    drive(1'b0, 12'h000);
    lat = 0;
    while (!bus.move_done && lat < 10) begin
      @(posedge CLOCK_50);
      #1;
      lat++;
    end
  endtask

  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (bus.move_done) seen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rdy, lat, seen;

    vecs[0] = '{12'h863, 3, 0, 1, 15, 0, 1, 3'd4, 3'd3, 0,  3'd4, 3'd1, 15};
    vecs[1] = '{12'h002, 2, 2, 0, -1, 0, 1, 3'd0, 3'd0, 3,  3'd0, 3'd2, 15};
    vecs[2] = '{12'h71D, 2, 1, 0, -1, 0, 1, 3'd3, 3'd4, 15, 3'd3, 3'd5, 15};
    vecs[3] = '{12'h1C6, 2, 3, 0, -1, 0, 1, 3'd0, 3'd7, 9,  3'd0, 3'd6, 6};
    vecs[4] = '{12'h38E, 2, 3, 0, -1, 0, 1, 3'd1, 3'd6, 6,  3'd1, 3'd7, 7};
    vecs[5] = '{12'h79C, 3, 0, 1, 15, 1, 2, 3'd3, 3'd4, 6,  3'd3, 3'd6, 15};
    vecs[6] = '{12'h8DC, 3, 0, 1, 6,  0, 3, 3'd3, 3'd4, 0,  3'd4, 3'd3, 15};
    vecs[7] = '{12'h7DC, 3, 0, 1, 0,  1, 4, 3'd3, 3'd4, 10, 3'd3, 3'd7, 15};
    vecs[8] = '{12'h862, 2, 1, 0, -1, 1, 4, 3'd4, 3'd2, 15, 3'd4, 3'd1, 15};
    vecs[9] = '{12'h001, 2, 3, 0, -1, 1, 4, 3'd0, 3'd0, 3,  3'd0, 3'd1, 0};

    doReset();
    checkOutput("rst_king",     int'(board[4][0]), 5);
    checkOutput("rst_p0_queen", int'(board[3][7]), 10);
    checkOutput("rst_p1_pawn",  int'(board[0][1]), 0);
    checkOutput("rst_p0_pawn",  int'(board[5][6]), 6);
    checkOutput("rst_empty",    int'(board[4][4]), 15);
    checkStartBoard("rst_board");
    checkOutput("rst_player",   int'(player), 1);
    checkOutput("rst_ready",    int'(bus.move_ready), 1);
    checkOutput("rst_count",    int'(count), 0);
    checkOutput("rst_done",     int'(bus.move_done), 0);
    checkOutput("rst_ok",       int'(bus.move_ok), 0);
    checkOutput("rst_err",      int'(bus.err_code), 0);
    checkOutput("rst_cap",      int'(bus.captured_piece), 15);
    checkOutput("rst_over",     int'(go), 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].pkt, rdy, lat);
      checkOutput($sformatf("vec%0d_ready_low", i), rdy, 0);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d_err", i), int'(bus.err_code), vecs[i].err);
      checkOutput($sformatf("vec%0d_ok", i), int'(bus.move_ok), vecs[i].ok);
      if (vecs[i].cap >= 0)
        checkOutput($sformatf("vec%0d_cap", i), int'(bus.captured_piece), vecs[i].cap);
      checkOutput($sformatf("vec%0d_player", i), int'(player), vecs[i].player);
      checkOutput($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      checkOutput($sformatf("vec%0d_sq1", i), int'(board[vecs[i].x1][vecs[i].y1]), vecs[i].v1);
      checkOutput($sformatf("vec%0d_sq2", i), int'(board[vecs[i].x2][vecs[i].y2]), vecs[i].v2);
      @(posedge CLOCK_50);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), int'(bus.move_done), 0);
      checkOutput($sformatf("vec%0d_ready_back", i), int'(bus.move_ready), 1);
    end

    doReset();
    applyStimulus(12'h047, rdy, lat);
    checkOutput("promo_latency",  lat, 3);
    checkOutput("promo_cap",      int'(bus.captured_piece), 9);
    checkOutput("promo_queen",    int'(board[0][7]), 4);
    checkOutput("promo_src",      int'(board[0][1]), 15);
    checkOutput("nopromo_cap",    int'(bus_np.captured_piece), 9);
    checkOutput("nopromo_pawn",   int'(board_np[0][7]), 0);
    checkOutput("nopromo_src",    int'(board_np[0][1]), 15);

    doReset();
    applyStimulus(12'h027, rdy, lat);
    checkOutput("king_latency", lat, 3);
    checkOutput("king_ok",      int'(bus.move_ok), 1);
    checkOutput("king_cap",     int'(bus.captured_piece), 11);
    checkOutput("king_over",    int'(go), 1);
    checkOutput("king_winner",  int'(win), 1);
    checkOutput("king_count",   int'(count), 1);
    @(negedge CLOCK_50);
    drive(1'b1, 12'h79D);
    countDone(5, seen);
    drive(1'b0, 12'h000);
    checkOutput("over_ready",    int'(bus.move_ready), 0);
    checkOutput("over_no_done",  seen, 0);
    checkOutput("over_board",    int'(board[3][6]), 6);
    checkOutput("over_count",    int'(count), 1);
    pulseNewGame();
    checkStartBoard("ng_board");
    checkOutput("ng_ready",  int'(bus.move_ready), 1);
    checkOutput("ng_over",   int'(go), 0);
    checkOutput("ng_count",  int'(count), 0);
    checkOutput("ng_player", int'(player), 1);
    checkOutput("ng_cap",    int'(bus.captured_piece), 15);

    // new_game while the accepted move sits in CHECK
    @(negedge CLOCK_50);
    drive(1'b1, 12'h863);
    @(posedge CLOCK_50);
    #1;
    drive(1'b0, 12'h000);
    pulseNewGame();
    countDone(6, seen);
    checkOutput("abort_no_done", seen, 0);
    checkOutput("abort_src",     int'(board[4][1]), 0);
    checkOutput("abort_dst",     int'(board[4][3]), 15);
    checkOutput("abort_count",   int'(count), 0);
    checkOutput("abort_player",  int'(player), 1);
    checkOutput("abort_ready",   int'(bus.move_ready), 1);

    // new_game and move_valid in the same cycle
    @(negedge CLOCK_50);
    drive(1'b1, 12'h863);
    new_game = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checkOutput("ng_wins_ready", int'(bus.move_ready), 1);
    drive(1'b0, 12'h000);
    new_game = 1'b0;
    countDone(5, seen);
    checkOutput("ng_wins_no_done", seen, 0);
    checkOutput("ng_wins_dst",     int'(board[4][3]), 15);

    // reset asserted while the move is in APPLY
    @(negedge CLOCK_50);
    drive(1'b1, 12'h863);
    @(posedge CLOCK_50);
    #1;
    drive(1'b0, 12'h000);
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b0;
    #1;
    checkStartBoard("midrst_board");
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_ready", int'(bus.move_ready), 1);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    countDone(4, seen);
    checkOutput("midrst_no_done", seen, 0);
    checkOutput("midrst_dst",     int'(board[4][3]), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
